// File: rtl/bit_plane_memory.sv
// Multi-slice bit-plane store: indexed bit read/write, whole-slice load, valid/ready slice dump.
// Optional build macro BIT_PLANE_MEM_XOR_EN turns bit writes into in-place XOR accumulates.
module bit_plane_memory #(
    parameter int WIDTH = 25,
    parameter int DEPTH = 64,
    parameter int IDX_W = 5,
    parameter int SLC_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             init,
    input  logic [WIDTH-1:0] line,
    input  logic [SLC_W-1:0] slice,
    input  logic [IDX_W-1:0] index,
    input  logic             val,
    input  logic             write,
    input  logic             read,
    output logic             out,
    output logic             out_valid,
    output logic             err,
    input  logic             dump_start,
    output logic [WIDTH-1:0] dump_data,
    output logic [SLC_W-1:0] dump_slice,
    output logic             dump_valid,
    input  logic             dump_ready,
    output logic             busy
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_DUMP = 1'b1
    } state_t;

    state_t           r_state;
    logic [SLC_W-1:0] r_ptr;
    logic             r_out;
    logic             r_out_valid;
    logic             r_err;

    logic             w_busy;
    logic             w_slice_ok;
    logic             w_idx_ok;
    logic             w_rd_ok;
    logic [IDX_W-1:0] w_phys;
    logic             w_init_en;
    logic             w_wr_en;
    logic             w_reject;
    logic [WIDTH-1:0] w_row;
    logic [WIDTH-1:0] w_mem [DEPTH];

    assign w_busy     = (r_state == S_DUMP);
    assign w_slice_ok = (int'(slice) < DEPTH);
    assign w_idx_ok   = (int'(index) < WIDTH);
    assign w_rd_ok    = w_slice_ok & w_idx_ok;
    // Logical index 0 is the slice MSB.
    assign w_phys     = IDX_W'(WIDTH - 1) - index;

    // Init shares the slice select with write, so a concurrent write always loses to init.
    assign w_init_en = init & w_slice_ok & ~w_busy;
    assign w_wr_en   = write & ~init & w_rd_ok & ~w_busy;

    assign w_reject = (read & ~w_rd_ok)
                    | (init & (~w_slice_ok | w_busy))
                    | (write & ~init & (~w_rd_ok | w_busy));

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slice
            logic [WIDTH-1:0] r_bits;
            logic             w_sel;

            assign w_sel = (slice == SLC_W'(gi));

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_bits <= '0;
                end else if (w_init_en && w_sel) begin
                    r_bits <= line;
                end else if (w_wr_en && w_sel) begin
`ifdef BIT_PLANE_MEM_XOR_EN
                    r_bits[w_phys] <= r_bits[w_phys] ^ val;
`else
                    r_bits[w_phys] <= val;
`endif
                end
            end

            assign w_mem[gi] = r_bits;
        end
    endgenerate

    // Reads see the pre-edge contents, giving read-before-write ordering for free.
    assign w_row = w_mem[slice];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out       <= 1'b0;
            r_out_valid <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_out_valid <= read;
            r_err       <= w_reject;
            if (read) begin
                r_out <= w_rd_ok ? w_row[w_phys] : 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_ptr   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (dump_start) begin
                        r_state <= S_DUMP;
                        r_ptr   <= '0;
                    end
                end
                S_DUMP: begin
                    if (dump_ready) begin
                        if (r_ptr == SLC_W'(DEPTH - 1)) begin
                            r_state <= S_IDLE;
                            r_ptr   <= '0;
                        end else begin
                            r_ptr <= r_ptr + 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_ptr   <= '0;
                end
            endcase
        end
    end

    // Memory is frozen while dumping, so the selected slice is stable across stalls.
    assign out        = r_out;
    assign out_valid  = r_out_valid;
    assign err        = r_err;
    assign busy       = w_busy;
    assign dump_valid = w_busy;
    assign dump_slice = w_busy ? r_ptr : '0;
    assign dump_data  = w_busy ? w_mem[r_ptr] : '0;

endmodule

// File: tb/tb_bit_plane_memory.sv
// Bench for bit_plane_memory: directed vector table, dump sequences, reset mid-dump,
// and randomized traffic checked against an array-based reference model.
module tb_bit_plane_memory;

    localparam int WIDTH = 25;
    localparam int DEPTH = 64;
    localparam int IDX_W = 5;
    localparam int SLC_W = 6;

    logic             clk;
    logic             rst;
    logic             init;
    logic [WIDTH-1:0] line;
    logic [SLC_W-1:0] slice;
    logic [IDX_W-1:0] index;
    logic             val;
    logic             write;
    logic             read;
    logic             out;
    logic             out_valid;
    logic             err;
    logic             dump_start;
    logic [WIDTH-1:0] dump_data;
    logic [SLC_W-1:0] dump_slice;
    logic             dump_valid;
    logic             dump_ready;
    logic             busy;

    bit_plane_memory #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .IDX_W(IDX_W), .SLC_W(SLC_W)
    ) dut (
        .clk(clk), .rst(rst), .init(init), .line(line), .slice(slice),
        .index(index), .val(val), .write(write), .read(read), .out(out),
        .out_valid(out_valid), .err(err), .dump_start(dump_start),
        .dump_data(dump_data), .dump_slice(dump_slice), .dump_valid(dump_valid),
        .dump_ready(dump_ready), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int n_txn    = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference model: plain array of slices plus dump progress.
    logic [WIDTH-1:0] m_mem [DEPTH];
    bit               m_busy;
    int               m_ptr;
    logic             m_out;

    function automatic void model_reset();
        for (int s = 0; s < DEPTH; s++) m_mem[s] = '0;
        m_busy = 1'b0;
        m_ptr  = 0;
        m_out  = 1'b0;
    endfunction

    // One clock of stimulus; expectations come from the model, compared #1 after the edge.
    task automatic drive(input logic i_init, input logic [WIDTH-1:0] i_line, input int i_slice,
                         input int i_index, input logic i_val, input logic i_write,
                         input logic i_read, input logic i_start, input logic i_ready);
        bit   s_ok, i_ok;
        logic e_err;
        int   p;
        init = i_init; line = i_line; slice = SLC_W'(i_slice); index = IDX_W'(i_index);
        val = i_val; write = i_write; read = i_read; dump_start = i_start; dump_ready = i_ready;

        s_ok  = (i_slice < DEPTH);
        i_ok  = (i_index < WIDTH);
        p     = WIDTH - 1 - i_index;
        e_err = (i_read && !(s_ok && i_ok)) || (i_init && (m_busy || !s_ok)) ||
                (i_write && !i_init && (m_busy || !s_ok || !i_ok));
        if (i_read) m_out = (s_ok && i_ok) ? m_mem[i_slice][p] : 1'b0;
        if (i_init && !m_busy && s_ok) begin
            m_mem[i_slice] = i_line;
        end else if (i_write && !i_init && !m_busy && s_ok && i_ok) begin
`ifdef BIT_PLANE_MEM_XOR_EN
            m_mem[i_slice][p] = m_mem[i_slice][p] ^ i_val;
`else
            m_mem[i_slice][p] = i_val;
`endif
        end
        if (m_busy) begin
            if (i_ready) begin
                if (m_ptr == DEPTH - 1) m_busy = 1'b0;
                else m_ptr++;
            end
        end else if (i_start) begin
            m_busy = 1'b1;
            m_ptr  = 0;
        end

        @(posedge clk);
        #1;
        n_txn++;
        $display("txn %0d init=%0b wr=%0b rd=%0b slice=%0d idx=%0d val=%0b start=%0b rdy=%0b -> out=%0b ov=%0b err=%0b busy=%0b dslice=%0d",
                 n_txn, i_init, i_write, i_read, i_slice, i_index, i_val, i_start, i_ready,
                 out, out_valid, err, busy, dump_slice);
        chk("out", 32'(out), 32'(m_out));
        chk("out_valid", 32'(out_valid), 32'(i_read));
        chk("err", 32'(err), 32'(e_err));
        chk("busy", 32'(busy), 32'(m_busy));
        chk("dump_valid", 32'(dump_valid), 32'(m_busy));
        if (m_busy) begin
            chk("dump_slice", 32'(dump_slice), 32'(m_ptr));
            chk("dump_data", 32'(dump_data), 32'(m_mem[m_ptr]));
        end
    endtask

    task automatic idle_cycle();
        drive(1'b0, '0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    typedef struct {
        string            name;
        logic             init;
        logic [WIDTH-1:0] line;
        int               slice;
        int               index;
        logic             val;
        logic             write;
        logic             read;
        logic             exp_out;
        logic             exp_valid;
        logic             exp_err;
    } vec_t;

    vec_t vecs[14];

    function automatic vec_t mk(input string n, input logic i, input logic [WIDTH-1:0] l,
                                input int s, input int x, input logic v, input logic w,
                                input logic r, input logic eo, input logic ev, input logic ee);
        vec_t t;
        t.name = n; t.init = i; t.line = l; t.slice = s; t.index = x; t.val = v;
        t.write = w; t.read = r; t.exp_out = eo; t.exp_valid = ev; t.exp_err = ee;
        return t;
    endfunction

    task automatic pulse_reset();
        #1;
        rst = 1'b1;
        init = 0; write = 0; read = 0; dump_start = 0; dump_ready = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        int beats;
        int guard;
        logic [WIDTH-1:0] held;
        logic held_ok;
        logic x_reread;

`ifdef BIT_PLANE_MEM_XOR_EN
        x_reread = 1'b0;
`else
        x_reread = 1'b1;
`endif
        vecs[0]  = mk("init_s3",      1, 25'h1000001, 3,  0, 0, 0, 0, 0, 0, 0);
        vecs[1]  = mk("rd_s3_i0",     0, '0,          3,  0, 0, 0, 1, 1, 1, 0);
        vecs[2]  = mk("rd_s3_i12",    0, '0,          3, 12, 0, 0, 1, 0, 1, 0);
        vecs[3]  = mk("rbw_s3_i12",   0, '0,          3, 12, 1, 1, 1, 0, 1, 0);
        vecs[4]  = mk("reread_i12",   0, '0,          3, 12, 0, 0, 1, 1, 1, 0);
        vecs[5]  = mk("wr_again_i12", 0, '0,          3, 12, 1, 1, 0, 1, 0, 0);
        vecs[6]  = mk("reread2_i12",  0, '0,          3, 12, 0, 0, 1, x_reread, 1, 0);
        vecs[7]  = mk("rd_idx25",     0, '0,          3, 25, 0, 0, 1, 0, 1, 1);
        vecs[8]  = mk("wr_idx30",     0, '0,          3, 30, 1, 1, 0, 0, 0, 1);
        vecs[9]  = mk("rd_s3_i24",    0, '0,          3, 24, 0, 0, 1, 1, 1, 0);
        vecs[10] = mk("rd_s3_i1",     0, '0,          3,  1, 0, 0, 1, 0, 1, 0);
        vecs[11] = mk("init_wins",    1, 25'h1FFFFFF, 5,  0, 0, 1, 0, 0, 0, 0);
        vecs[12] = mk("rd_s5_i0",     0, '0,          5,  0, 0, 0, 1, 1, 1, 0);
        vecs[13] = mk("rd_idx31",     0, '0,         31, 31, 0, 0, 1, 0, 1, 1);

        rst = 1'b1;
        init = 0; line = '0; slice = '0; index = '0; val = 0; write = 0; read = 0;
        dump_start = 0; dump_ready = 0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out", 32'(out), 0);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_dump_valid", 32'(dump_valid), 0);
        chk("rst_dump_data", 32'(dump_data), 0);
        chk("rst_dump_slice", 32'(dump_slice), 0);
        chk("rst_busy", 32'(busy), 0);
        rst = 1'b0;

        // Directed table.
        for (int k = 0; k < 14; k++) begin
            init = vecs[k].init; line = vecs[k].line; slice = SLC_W'(vecs[k].slice);
            index = IDX_W'(vecs[k].index); val = vecs[k].val; write = vecs[k].write;
            read = vecs[k].read; dump_start = 0; dump_ready = 0;
            @(posedge clk);
            #1;
            n_txn++;
            $display("txn %0d vec %s -> out=%0b ov=%0b err=%0b", n_txn, vecs[k].name, out, out_valid, err);
            chk({vecs[k].name, "_out"}, 32'(out), 32'(vecs[k].exp_out));
            chk({vecs[k].name, "_valid"}, 32'(out_valid), 32'(vecs[k].exp_valid));
            chk({vecs[k].name, "_err"}, 32'(err), 32'(vecs[k].exp_err));
        end

        // Full dump with toggling ready, a rejected write and a read mid-dump.
        pulse_reset();
        for (int s = 0; s < DEPTH; s++) drive(1'b1, WIDTH'(s), s, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b0, '0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        beats = 0;
        guard = 0;
        held_ok = 1'b0;
        held = '0;
        while (m_busy && guard < 400) begin
            logic rdy;
            rdy = (guard % 2 == 0);
            if (held_ok) chk("stall_stable", 32'(dump_data), 32'(held));
            held_ok = 1'b0;
            if (dump_valid && rdy) begin
                chk("beat_data", 32'(dump_data), 32'(dump_slice));
                beats++;
            end else if (dump_valid) begin
                held = dump_data;
                held_ok = 1'b1;
            end
            if (guard == 5)      drive(1'b0, '0, 0, 0, 1'b1, 1'b1, 1'b0, 1'b0, rdy);
            else if (guard == 7) drive(1'b0, '0, 9, 24, 1'b0, 1'b0, 1'b1, 1'b0, rdy);
            else if (guard == 9) drive(1'b1, 25'h0ABCDE, 2, 0, 1'b0, 1'b0, 1'b1, 1'b0, rdy);
            else                 drive(1'b0, '0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, rdy);
            guard++;
        end
        chk("dump_beats", 32'(beats), DEPTH);
        chk("dump_done_busy", 32'(busy), 0);
        drive(1'b0, '0, 0, 0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        drive(1'b0, '0, 2, 20, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

        // Randomized traffic.
        for (int n = 0; n < 400; n++) begin
            logic ri, rw, rr, rs, ry;
            int   rsl, rix;
            ri  = ($urandom_range(0, 7) == 0);
            rw  = ($urandom_range(0, 2) == 0);
            rr  = ($urandom_range(0, 1) == 0);
            rs  = ($urandom_range(0, 29) == 0);
            ry  = ($urandom_range(0, 3) != 0);
            rsl = $urandom_range(0, DEPTH - 1);
            rix = $urandom_range(0, 31);
            if (ri && rix >= WIDTH) rw = 1'b0;
            drive(ri, WIDTH'($urandom), rsl, rix, 1'(($urandom)), rw, rr, rs, ry);
        end
        guard = 0;
        while (m_busy && guard < 200) begin
            drive(1'b0, '0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
            guard++;
        end
        chk("rand_drain", 32'(busy), 0);

        // Reset during a dump aborts it and clears memory.
        for (int s = 0; s < DEPTH; s++) drive(1'b1, WIDTH'(s + 1), s, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b0, '0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        guard = 0;
        while (m_ptr != 10 && guard < 100) begin
            drive(1'b0, '0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
            guard++;
        end
        chk("reach_beat10", 32'(dump_slice), 10);
        #2;
        rst = 1'b1;
        #1;
        chk("abort_dump_valid", 32'(dump_valid), 0);
        chk("abort_busy", 32'(busy), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        dump_ready = 1'b0;
        model_reset();
        for (int n = 0; n < 6; n++) drive(1'b0, '0, $urandom_range(0, DEPTH - 1),
                                          $urandom_range(0, WIDTH - 1), 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        drive(1'b0, '0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("restart_slice0", 32'(dump_slice), 0);
        guard = 0;
        while (m_busy && guard < 200) begin
            drive(1'b0, '0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
            guard++;
        end
        chk("final_busy", 32'(busy), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
